// File: rtl/addsub_arbiter_if.sv
// Bus bundle for addsub_arbiter: two requester ports, the result channel and status.
interface addsub_arbiter_if;
    logic       req0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       sub0;
    logic       gnt0;

    logic       req1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       sub1;
    logic       gnt1;

    logic       res_valid;
    logic       res_id;
    logic [4:0] res_value;
    logic       res_ready;

    logic       busy;
    logic [7:0] op_count;

    // Arbiter side
    modport slave (
        input  req0, a0, b0, sub0,
        input  req1, a1, b1, sub1,
        input  res_ready,
        output gnt0, gnt1,
        output res_valid, res_id, res_value,
        output busy, op_count
    );

    // Requester / consumer side
    modport master (
        output req0, a0, b0, sub0,
        output req1, a1, b1, sub1,
        output res_ready,
        input  gnt0, gnt1,
        input  res_valid, res_id, res_value,
        input  busy, op_count
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter feeding a shared 4-bit add/subtract unit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; combinational grant to the winner, capture on edge
// EXEC  | compute result from captured operands
// RESP  | hold result with res_valid until res_ready
module addsub_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    addsub_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // last-served value that makes FIRST_PRIO win the first contended grant
    localparam logic LAST_INIT = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t     state;
    logic       last;
    logic       op_id;
    logic       op_sub;
    logic [3:0] op_a;
    logic [3:0] op_b;

    logic       res_valid_q;
    logic       res_id_q;
    logic [4:0] res_value_q;
    logic [7:0] op_count_q;

    logic       winner;
    logic       grant;
    logic [4:0] sum_add;
    logic [4:0] sum_sub;
    logic [4:0] next_value;

    // Arbitration: single requester wins outright, contention goes to the one not served last.
    // Grant is gated by rst so it drops asynchronously with reset.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1)
            winner = ~last;
        else if (bus.req1)
            winner = 1'b1;
        grant = (state == IDLE) && (bus.req0 || bus.req1) && !rst;
    end

    assign bus.gnt0 = grant && !winner;
    assign bus.gnt1 = grant &&  winner;

    // Datapath: subtract is A + ~B + 1 with the carry inverted to give borrow.
    always_comb begin
        sum_add = {1'b0, op_a} + {1'b0, op_b};
        sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + 5'd1;
        if (op_sub)
            next_value = {~sum_sub[4], sum_sub[3:0]};
        else
            next_value = sum_add;
    end

    // Sequencer: capture on grant, compute in EXEC, hand off in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= LAST_INIT;
            op_id       <= 1'b0;
            op_sub      <= 1'b0;
            op_a        <= 4'd0;
            op_b        <= 4'd0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_value_q <= 5'd0;
            op_count_q  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_id  <= winner;
                        op_a   <= winner ? bus.a1   : bus.a0;
                        op_b   <= winner ? bus.b1   : bus.b0;
                        op_sub <= winner ? bus.sub1 : bus.sub0;
                        last   <= winner;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_value_q <= next_value;
                    res_id_q    <= op_id;
                    res_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_value = res_value_q;
    assign bus.op_count  = op_count_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: latency, arithmetic vectors, round-robin, stall, reset abort, wrap.
module tb_addsub_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_arbiter_if bus ();

    addsub_arbiter #(.FIRST_PRIO(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_count;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one uncontended operation with res_ready=1, checking grant, latency and result
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic sub, input logic [4:0] expv);
        bus.res_ready = 1'b1;
        if (id) begin
            bus.req0 = 1'b0; bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sub1 = sub;
        end else begin
            bus.req1 = 1'b0; bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sub0 = sub;
        end
        #1;
        check("op_gnt0", 16'(bus.gnt0), 16'(!id));
        check("op_gnt1", 16'(bus.gnt1), 16'(id));
        tick;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check("exec_busy",  16'(bus.busy), 16'd1);
        check("exec_valid", 16'(bus.res_valid), 16'd0);
        tick;
        check("resp_valid", 16'(bus.res_valid), 16'd1);
        check("resp_id",    16'(bus.res_id), 16'(id));
        check("resp_value", 16'(bus.res_value), 16'(expv));
        tick;
        exp_count = exp_count + 8'd1;
        check("done_valid", 16'(bus.res_valid), 16'd0);
        check("done_busy",  16'(bus.busy), 16'd0);
        check("op_count",   16'(bus.op_count), 16'(exp_count));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        exp_count = 8'd0;
        #1;
    endtask

    // hand-computed arithmetic vectors: {id, a, b, sub, expected}
    logic       v_id  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] v_a   [8] = '{4'd9, 4'd3, 4'd7, 4'd15, 4'd0, 4'd0, 4'd8, 4'd4};
    logic [3:0] v_b   [8] = '{4'd8, 4'd5, 4'd2, 4'd15, 4'd0, 4'd1, 4'd8, 4'd3};
    logic       v_sub [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] v_exp [8] = '{5'b10001, 5'b11110, 5'b00101, 5'b11110,
                              5'b00000, 5'b11111, 5'b00000, 5'b00111};

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0; bus.sub0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0; bus.sub1 = 1'b0;
        bus.res_ready = 1'b1;
        exp_count = 8'd0;

        // reset state, grant suppressed even with a request present
        tick;
        bus.req0 = 1'b1;
        #1;
        check("rst_gnt0",      16'(bus.gnt0), 16'd0);
        check("rst_gnt1",      16'(bus.gnt1), 16'd0);
        check("rst_valid",     16'(bus.res_valid), 16'd0);
        check("rst_id",        16'(bus.res_id), 16'd0);
        check("rst_value",     16'(bus.res_value), 16'd0);
        check("rst_busy",      16'(bus.busy), 16'd0);
        check("rst_op_count",  16'(bus.op_count), 16'd0);
        do_reset;

        // arithmetic vectors
        for (int i = 0; i < 8; i++)
            run_op(v_id[i], v_a[i], v_b[i], v_sub[i], v_exp[i]);

        // contended round-robin from reset: 0,1,0,1 with 3 cycles between grants
        do_reset;
        bus.res_ready = 1'b1;
        bus.a0 = 4'd1; bus.b0 = 4'd1; bus.sub0 = 1'b0;
        bus.a1 = 4'd6; bus.b1 = 4'd2; bus.sub1 = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_gnt0", 16'(bus.gnt0), 16'((k % 2) == 0));
            check("rr_gnt1", 16'(bus.gnt1), 16'((k % 2) == 1));
            tick;
            check("rr_exec_gnt", 16'({bus.gnt0, bus.gnt1}), 16'd0);
            tick;
            check("rr_resp_gnt", 16'({bus.gnt0, bus.gnt1}), 16'd0);
            check("rr_resp_id",  16'(bus.res_id), 16'(k % 2));
            check("rr_resp_val", 16'(bus.res_value), ((k % 2) == 0) ? 16'h02 : 16'h04);
            tick;
            exp_count = exp_count + 8'd1;
            check("rr_op_count", 16'(bus.op_count), 16'(exp_count));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // stall in RESP; operand and request changes while busy have no effect
        bus.res_ready = 1'b0;
        bus.a0 = 4'd12; bus.b0 = 4'd5; bus.sub0 = 1'b1;
        bus.req0 = 1'b1;
        #1;
        check("stall_gnt0", 16'(bus.gnt0), 16'd1);
        tick;
        bus.req0 = 1'b0;
        bus.a0 = 4'd0;
        bus.b0 = 4'd15;
        bus.req1 = 1'b1;
        #1;
        check("stall_exec_gnt1", 16'(bus.gnt1), 16'd0);
        tick;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 16'(bus.res_valid), 16'd1);
            check("stall_value", 16'(bus.res_value), 16'h07);
            check("stall_id",    16'(bus.res_id), 16'd0);
            check("stall_gnt",   16'({bus.gnt0, bus.gnt1}), 16'd0);
            check("stall_busy",  16'(bus.busy), 16'd1);
            check("stall_cnt",   16'(bus.op_count), 16'(exp_count));
            tick;
        end
        bus.res_ready = 1'b1;
        bus.a1 = 4'd2; bus.b1 = 4'd9; bus.sub1 = 1'b0;
        tick;
        exp_count = exp_count + 8'd1;
        check("stall_release_valid", 16'(bus.res_valid), 16'd0);
        check("stall_release_cnt",   16'(bus.op_count), 16'(exp_count));
        check("pending_gnt1",        16'(bus.gnt1), 16'd1);
        tick;
        bus.req1 = 1'b0;
        tick;
        check("pending_value", 16'(bus.res_value), 16'h0B);
        check("pending_id",    16'(bus.res_id), 16'd1);
        tick;
        exp_count = exp_count + 8'd1;
        check("pending_cnt", 16'(bus.op_count), 16'(exp_count));

        // reset during EXEC discards the operation
        do_reset;
        bus.a0 = 4'd5; bus.b0 = 4'd5; bus.sub0 = 1'b0;
        bus.req0 = 1'b1;
        tick;
        bus.req0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy",  16'(bus.busy), 16'd0);
        check("abort_valid", 16'(bus.res_valid), 16'd0);
        check("abort_value", 16'(bus.res_value), 16'd0);
        check("abort_cnt",   16'(bus.op_count), 16'd0);
        tick;
        tick;
        check("abort_hold_valid", 16'(bus.res_valid), 16'd0);
        rst = 1'b0;
        exp_count = 8'd0;
        #1;
        check("abort_after_cnt", 16'(bus.op_count), 16'd0);
        // first edge after reset release takes the grant
        run_op(1'b0, 4'd5, 4'd5, 1'b0, 5'b01010);

        // 256 handshakes wrap op_count to 0
        do_reset;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       sub;
            logic [4:0] expv;
            a   = 4'(i);
            b   = 4'(i >> 4);
            sub = ((i % 3) == 0);
            if (sub)
                expv = {(a < b), 4'(a - b)};
            else
                expv = 5'({1'b0, a}) + 5'({1'b0, b});
            run_op(1'(i % 2), a, b, sub, expv);
        end
        check("wrap_op_count", 16'(bus.op_count), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
